// File: rtl/lifo_stack.sv
// LIFO stack with registered top/next-on-stack outputs and sticky overflow/underflow flags.
// Define LIFO_STACK_CIRCULAR_EN to let a push onto a full stack overwrite the oldest entry.
module lifo_stack #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;

  logic [WIDTH-1:0] tos_n, nos_n, wr_data;
  logic [CW-1:0]    count_n;
  logic [AW-1:0]    sp_n, wr_addr;
  logic             wr_en, ovf_set, unf_set;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // sp points at the next free slot; tos lives at sp-1 and nos at sp-2, so the
  // entry that becomes nos after a pop sits at sp-3.
  always_comb begin
    tos_n   = tos;
    nos_n   = nos;
    count_n = count;
    sp_n    = sp;
    wr_en   = 1'b0;
    wr_addr = sp;
    wr_data = d;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (push && pop && !empty) begin
      wr_en   = 1'b1;
      wr_addr = sp - AW'(1);
      tos_n   = d;
    end else if (push) begin
      if (!full) begin
        wr_en   = 1'b1;
        sp_n    = sp + AW'(1);
        tos_n   = d;
        nos_n   = tos;
        count_n = count + CW'(1);
      end else begin
`ifdef LIFO_STACK_CIRCULAR_EN
        // When full, sp equals the bottom slot, so this write drops the oldest entry.
        wr_en   = 1'b1;
        sp_n    = sp + AW'(1);
        tos_n   = d;
        nos_n   = tos;
`else
        ovf_set = 1'b1;
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        sp_n    = sp - AW'(1);
        tos_n   = nos;
        nos_n   = (count >= CW'(3)) ? mem[sp - AW'(3)] : '0;
        count_n = count - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
      tos   <= '0;
      nos   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      sp    <= sp_n;
      count <= count_n;
      tos   <= tos_n;
      nos   <= nos_n;
      ovf   <= (ovf & ~clr_err) | ovf_set;
      unf   <= (unf & ~clr_err) | unf_set;
    end
  end

  // Storage is left uninitialised; reset only clears the pointer and output registers.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=4).
module tb_lifo_stack;

  logic       clk = 1'b0;
  logic       reset, push, pop, clr_err;
  logic [7:0] d;
  logic [7:0] tos, nos;
  logic [2:0] count;
  logic       empty, full, ovf, unf;

  int checks = 0;
  int failures = 0;

  lifo_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d), .clr_err(clr_err),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; clr_err = 0; reset = 0; d = 8'h00;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  task automatic push_one(input logic [7:0] v);
    idle(); push = 1; d = v; step(); idle();
  endtask

  task automatic pop_one();
    idle(); pop = 1; step(); idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 3'd0 || tos !== 8'h00 || nos !== 8'h00 || ovf !== 1'b0 || unf !== 1'b0 ||
        empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%0d tos=%h nos=%h ovf=%b unf=%b empty=%b full=%b, expected 0/00/00/0/0/1/0",
               count, tos, nos, ovf, unf, empty, full);
    end
  endtask

  task automatic test_push();
    do_reset();
    push_one(8'h11);
    checks++;
    if (tos !== 8'h11 || nos !== 8'h00 || count !== 3'd1) begin
      failures++;
      $display("FAIL push1: tos=%h nos=%h count=%0d, expected 11/00/1", tos, nos, count);
    end
    push_one(8'h22);
    push_one(8'h33);
    checks++;
    if (tos !== 8'h33 || nos !== 8'h22 || count !== 3'd3 || empty !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL push3: tos=%h nos=%h count=%0d empty=%b full=%b, expected 33/22/3/0/0",
               tos, nos, count, empty, full);
    end
    step();
    checks++;
    if (tos !== 8'h33 || nos !== 8'h22 || count !== 3'd3) begin
      failures++;
      $display("FAIL idle_hold: tos=%h nos=%h count=%0d, expected 33/22/3", tos, nos, count);
    end
  endtask

  task automatic test_pop_underflow();
    logic [7:0] exp_tos [3];
    logic [7:0] exp_nos [3];
    exp_tos[0] = 8'h22; exp_tos[1] = 8'h11; exp_tos[2] = 8'h00;
    exp_nos[0] = 8'h11; exp_nos[1] = 8'h00; exp_nos[2] = 8'h00;
    do_reset();
    push_one(8'h11); push_one(8'h22); push_one(8'h33);
    for (int i = 0; i < 3; i++) begin
      pop_one();
      checks++;
      if (tos !== exp_tos[i] || nos !== exp_nos[i] || count !== 3'(2 - i)) begin
        failures++;
        $display("FAIL pop%0d: tos=%h nos=%h count=%0d, expected %h/%h/%0d",
                 i, tos, nos, count, exp_tos[i], exp_nos[i], 2 - i);
      end
    end
    checks++;
    if (unf !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL pop_to_empty: unf=%b empty=%b, expected 0/1", unf, empty);
    end
    pop_one();
    checks++;
    if (unf !== 1'b1 || count !== 3'd0 || empty !== 1'b1 || tos !== 8'h00) begin
      failures++;
      $display("FAIL underflow: unf=%b count=%0d empty=%b tos=%h, expected 1/0/1/00", unf, count, empty, tos);
    end
    idle(); clr_err = 1; step(); idle();
    checks++;
    if (unf !== 1'b0) begin
      failures++;
      $display("FAIL clr_unf: unf=%b, expected 0", unf);
    end
  endtask

  task automatic test_replace();
    do_reset();
    push_one(8'h11); push_one(8'h22); push_one(8'h33);
    idle(); push = 1; pop = 1; d = 8'hAA; step(); idle();
    checks++;
    if (tos !== 8'hAA || nos !== 8'h22 || count !== 3'd3 || ovf !== 1'b0 || unf !== 1'b0) begin
      failures++;
      $display("FAIL replace: tos=%h nos=%h count=%0d ovf=%b unf=%b, expected AA/22/3/0/0",
               tos, nos, count, ovf, unf);
    end
    pop_one();
    checks++;
    if (tos !== 8'h22 || nos !== 8'h11) begin
      failures++;
      $display("FAIL replace_pop: tos=%h nos=%h, expected 22/11", tos, nos);
    end
    do_reset();
    idle(); push = 1; pop = 1; d = 8'h55; step(); idle();
    checks++;
    if (tos !== 8'h55 || nos !== 8'h00 || count !== 3'd1 || unf !== 1'b0) begin
      failures++;
      $display("FAIL replace_empty: tos=%h nos=%h count=%0d unf=%b, expected 55/00/1/0", tos, nos, count, unf);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_pre [4];
    logic [7:0] exp_post [4];
    do_reset();
    for (int i = 1; i <= 5; i++) push_one(8'(i));
`ifdef LIFO_STACK_CIRCULAR_EN
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || tos !== 8'h05 || nos !== 8'h04 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL full_circ: count=%0d full=%b tos=%h nos=%h ovf=%b, expected 4/1/05/04/0",
               count, full, tos, nos, ovf);
    end
    exp_pre[0] = 8'h05; exp_pre[1] = 8'h04; exp_pre[2] = 8'h03; exp_pre[3] = 8'h02;
    exp_post[0] = 8'h04; exp_post[1] = 8'h03; exp_post[2] = 8'h02; exp_post[3] = 8'h00;
`else
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || tos !== 8'h04 || nos !== 8'h03 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL full_ovf: count=%0d full=%b tos=%h nos=%h ovf=%b, expected 4/1/04/03/1",
               count, full, tos, nos, ovf);
    end
    exp_pre[0] = 8'h04; exp_pre[1] = 8'h03; exp_pre[2] = 8'h02; exp_pre[3] = 8'h01;
    exp_post[0] = 8'h03; exp_post[1] = 8'h02; exp_post[2] = 8'h01; exp_post[3] = 8'h00;
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tos !== exp_pre[i] || tos === 8'hxx) begin
        failures++;
        $display("FAIL full_pop%0d: tos=%h, expected %h", i, tos, exp_pre[i]);
      end
      pop_one();
      checks++;
      if (tos !== exp_post[i]) begin
        failures++;
        $display("FAIL full_post%0d: tos=%h, expected %h", i, tos, exp_post[i]);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0 || nos !== 8'h00) begin
      failures++;
      $display("FAIL full_drain: empty=%b count=%0d nos=%h, expected 1/0/00", empty, count, nos);
    end
  endtask

  task automatic test_full_replace();
    do_reset();
    for (int i = 1; i <= 4; i++) push_one(8'(i));
    idle(); push = 1; pop = 1; d = 8'hEE; step(); idle();
    checks++;
    if (tos !== 8'hEE || nos !== 8'h03 || count !== 3'd4 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL full_replace: tos=%h nos=%h count=%0d ovf=%b, expected EE/03/4/0", tos, nos, count, ovf);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    idle(); pop = 1; clr_err = 1; step(); idle();
    checks++;
    if (unf !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: unf=%b, expected 1", unf);
    end
  endtask

  task automatic test_reset_override();
    do_reset();
    push_one(8'h10); push_one(8'h20);
    pop_one(); pop_one(); pop_one();
    idle(); reset = 1; push = 1; d = 8'h77; step(); idle();
    checks++;
    if (count !== 3'd0 || tos !== 8'h00 || nos !== 8'h00 || unf !== 1'b0 || ovf !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_override: count=%0d tos=%h nos=%h unf=%b ovf=%b empty=%b, expected 0/00/00/0/0/1",
               count, tos, nos, unf, ovf, empty);
    end
    push_one(8'h42);
    checks++;
    if (tos !== 8'h42 || nos !== 8'h00 || count !== 3'd1) begin
      failures++;
      $display("FAIL post_reset_push: tos=%h nos=%h count=%0d, expected 42/00/1", tos, nos, count);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_push();
    test_pop_underflow();
    test_replace();
    test_full();
    test_full_replace();
    test_set_wins();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
